// File: rtl/fifo_sc_pkg.sv
// fifo_sc_pkg: sizing helpers shared by the single-clock FIFO and its RAM.
package fifo_sc_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram_single_clock_dpram_sc.sv
// dpram_sc: simple dual-port RAM, one write port and one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module dpram_sc
  import fifo_sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              i_Clk,
  input  logic              i_Wr_En,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [WIDTH-1:0]  i_Wr_Data,
  input  logic              i_Rd_En,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [WIDTH-1:0]  o_Rd_Data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-during-write to the same address returns the old word.
  always_ff @(posedge i_Clk) begin
    if (i_Wr_En) mem[i_Wr_Addr] <= i_Wr_Data;
    if (i_Rd_En) o_Rd_Data <= mem[i_Rd_Addr];
  end

endmodule

// File: rtl/fifo_dpram_single_clock.sv
// fifo_dpram_single_clock: single-clock FIFO over a simple dual-port RAM.
// Define FIFO_SC_ERR_FLAGS_EN to add sticky o_Overflow/o_Underflow outputs.
module fifo_dpram_single_clock
  import fifo_sc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int MAKE_FWFT = 0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic [$clog2(DEPTH)-1:0] i_AF_Level,
  output logic                     o_AF_Flag,
  output logic                     o_Full,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data,
  input  logic [$clog2(DEPTH)-1:0] i_AE_Level,
  output logic                     o_AE_Flag,
  output logic                     o_Empty
`ifdef FIFO_SC_ERR_FLAGS_EN
  ,
  output logic                     o_Overflow,
  output logic                     o_Underflow
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t rd_nxt;
  ptr_t ram_addr;
  cnt_t count;

  logic wr_acc;
  logic rd_pop;
  logic byp;
  logic rd_adv;
  logic ram_re;
  logic load_byp;
  logic sel_byp;

  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] byp_q;

  // Write+read on an empty FIFO passes the word straight through.
  assign byp    = i_Wr_DV && i_Rd_En && o_Empty;
  assign wr_acc = i_Wr_DV && (!o_Full || i_Rd_En);
  assign rd_pop = i_Rd_En && !o_Empty;
  assign rd_adv = rd_pop || byp;
  assign rd_nxt = rd_adv ? rd_ptr + ptr_t'(1) : rd_ptr;

  // FWFT keeps the RAM prefetching the next head every cycle.
  always_comb begin
    ram_re   = rd_pop;
    ram_addr = rd_ptr;
    load_byp = byp;
    if (MAKE_FWFT != 0) begin
      ram_re   = 1'b1;
      ram_addr = rd_nxt;
      load_byp = byp || (wr_acc && (wr_ptr == rd_nxt));
    end
  end

  dpram_sc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_Clk     (i_Clk),
    .i_Wr_En   (wr_acc),
    .i_Wr_Addr (wr_ptr),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_En   (ram_re),
    .i_Rd_Addr (ram_addr),
    .o_Rd_Data (ram_q)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sel_byp <= 1'b1;
      byp_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      rd_ptr <= rd_nxt;
      case ({wr_acc, rd_adv})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      if (load_byp) begin
        sel_byp <= 1'b1;
        byp_q   <= i_Wr_Data;
      end else if (ram_re) begin
        sel_byp <= 1'b0;
      end
    end
  end

  assign o_Rd_Data = sel_byp ? byp_q : ram_q;

  assign o_Full    = (count == FULL_CNT);
  assign o_Empty   = (count == '0);
  assign o_AF_Flag = (count > (FULL_CNT - cnt_t'(i_AF_Level)));
  assign o_AE_Flag = (count <= cnt_t'(i_AE_Level));

`ifdef FIFO_SC_ERR_FLAGS_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (i_Wr_DV && o_Full && !i_Rd_En) o_Overflow <= 1'b1;
      if (i_Rd_En && o_Empty && !i_Wr_DV) o_Underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_dpram_single_clock.sv
// tb_fifo_dpram_single_clock: directed scoreboard bench for the single-clock FIFO.
// Optional FIFO_SC_ERR_FLAGS_EN ports are connected when that macro is defined.
module tb_fifo_dpram_single_clock;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int LVL   = 10;

  logic             clk;
  logic             rst;
  logic             wr_dv;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       af_lvl;
  logic [7:0]       ae_lvl;
  logic             af;
  logic             full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             ae;
  logic             empty;
`ifdef FIFO_SC_ERR_FLAGS_EN
  logic             ovf;
  logic             unf;
`endif

  int checks   = 0;
  int failures = 0;
  int mcnt     = 0;
  logic [7:0] last = 8'h00;
  logic [7:0] sb [$];

  fifo_dpram_single_clock #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .MAKE_FWFT (0)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Data  (wr_data),
    .i_AF_Level (af_lvl),
    .o_AF_Flag  (af),
    .o_Full     (full),
    .i_Rd_En    (rd_en),
    .o_Rd_Data  (rd_data),
    .i_AE_Level (ae_lvl),
    .o_AE_Flag  (ae),
    .o_Empty    (empty)
`ifdef FIFO_SC_ERR_FLAGS_EN
    ,
    .o_Overflow (ovf),
    .o_Underflow(unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic flags_chk();
    chk("full",  32'(full),  32'(mcnt == DEPTH));
    chk("empty", 32'(empty), 32'(mcnt == 0));
    chk("af",    32'(af),    32'(mcnt > DEPTH - LVL));
    chk("ae",    32'(ae),    32'(mcnt <= LVL));
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    bit w_ok;
    bit r_ok;
    bit bp;
    @(negedge clk);
    wr_dv   = wr;
    wr_data = d;
    rd_en   = rd;
    bp   = wr && rd && (mcnt == 0);
    w_ok = wr && ((mcnt != DEPTH) || rd);
    r_ok = rd && (mcnt != 0);
    @(posedge clk);
    #1;
    wr_dv = 1'b0;
    rd_en = 1'b0;
    if (bp) last = d;
    else if (r_ok) last = sb.pop_front();
    if (w_ok && !bp) sb.push_back(d);
    if (w_ok && !r_ok && !bp) mcnt++;
    else if (r_ok && !w_ok) mcnt--;
    chk("rd_data", 32'(rd_data), 32'(last));
    flags_chk();
  endtask

  initial begin
    rst     = 1'b1;
    wr_dv   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    af_lvl  = 8'(LVL);
    ae_lvl  = 8'(LVL);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae",    32'(ae),    32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_af",    32'(af),    32'd0);
    chk("rst_rdata", 32'(rd_data), 32'h0);
`ifdef FIFO_SC_ERR_FLAGS_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
`endif

    step(1'b1, 8'hA1, 1'b0);
    chk("a1_not_empty", 32'(empty), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("a1_data",  32'(rd_data), 32'hA1);
    chk("a1_empty", 32'(empty), 32'd1);
    chk("a1_full",  32'(full),  32'd0);

    for (int i = 0; i < 10; i++) step(1'b1, 8'(i * 7 + 3), 1'b0);
    chk("ae_at_10", 32'(ae), 32'd1);
    step(1'b1, 8'h5A, 1'b0);
    chk("ae_at_11", 32'(ae), 32'd0);

    for (int i = 11; i < 246; i++) step(1'b1, 8'(i * 13 + 1), 1'b0);
    chk("af_at_246", 32'(af), 32'd0);
    step(1'b1, 8'hC3, 1'b0);
    chk("af_at_247", 32'(af), 32'd1);

    for (int i = 247; i < 255; i++) step(1'b1, 8'(i ^ 8'h3C), 1'b0);
    chk("full_at_255", 32'(full), 32'd0);
    step(1'b1, 8'hEE, 1'b0);
    chk("full_at_256", 32'(full), 32'd1);
    step(1'b1, 8'h77, 1'b0);
    chk("full_drop", 32'(full), 32'd1);
    chk("sb_len", 32'(sb.size()), 32'd256);
`ifdef FIFO_SC_ERR_FLAGS_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`endif

    step(1'b1, 8'h99, 1'b1);
    chk("full_rw_full", 32'(full), 32'd1);

    for (int i = 0; i < 256; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_last",  32'(rd_data), 32'h99);
    step(1'b0, 8'h00, 1'b1);
    chk("extra_rd_hold",  32'(rd_data), 32'h99);
    chk("extra_rd_empty", 32'(empty), 32'd1);
`ifdef FIFO_SC_ERR_FLAGS_EN
    chk("unf_set", 32'(unf), 32'd1);
`endif

    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hB0 + i), 1'b1);
    chk("byp_last",  32'(rd_data), 32'hB9);
    step(1'b0, 8'h00, 1'b0);
    chk("byp_empty", 32'(empty), 32'd1);
    chk("byp_ae",    32'(ae),    32'd1);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_empty", 32'(empty),   32'd1);
    chk("midrst_rdata", 32'(rd_data), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    mcnt = 0;
    last = 8'h00;
    sb.delete();
    step(1'b1, 8'h6D, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_data", 32'(rd_data), 32'h6D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
